// File: rtl/mem_port_arbiter.sv
// N-channel memory port arbiter. It merges per-channel request/ack ports onto one external
// memory port with one transaction outstanding, using fixed-priority or round-robin arbitration.
module mem_port_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int XLEN        = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_CH-1:0]      i_req,
  input  logic [NUM_CH*XLEN-1:0] i_addr,
  input  logic [NUM_CH*XLEN-1:0] i_wdata,
  input  logic [NUM_CH*3-1:0]    i_funct3,
  input  logic [NUM_CH-1:0]      i_we,
  output logic [NUM_CH-1:0]      o_ack,
  output logic [NUM_CH-1:0]      o_err,
  output logic [XLEN-1:0]        o_rdata,
  output logic [NUM_CH-1:0]      o_grant,
  output logic                   o_busy,
  output logic                   o_mem_req,
  output logic [XLEN-1:0]        o_mem_addr,
  output logic [XLEN-1:0]        o_mem_data,
  output logic [2:0]             o_mem_funct3,
  output logic                   o_mem_we,
  input  logic                   i_mem_ack,
  input  logic [XLEN-1:0]        i_mem_data
);

  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNTW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNTW-1:0] TO_LAST_C = TO_LAST[CNTW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  logic [NUM_CH-1:0][XLEN-1:0] ch_addr, ch_wdata;
  logic [NUM_CH-1:0][2:0]      ch_f3;

  assign ch_addr  = i_addr;
  assign ch_wdata = i_wdata;
  assign ch_f3    = i_funct3;

  state_e              state_q, state_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ack_q, ack_d, err_q, err_d, grant_q, grant_d;
  logic [XLEN-1:0]     rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [2:0]          mem_f3_q, mem_f3_d;
  logic                busy_q, busy_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;

  // Winner search: round-robin starts one past the last owner, fixed starts at channel 0.
  logic [CW-1:0] win, idx;
  logic          found;
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 1) idx = CW'((int'(ptr_q) + 1 + i) % NUM_CH);
      else               idx = CW'(i);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    err_d      = err_q;
    grant_d    = grant_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_f3_d   = mem_f3_q;
    mem_we_d   = mem_we_q;
    case (state_q)
      S_IDLE: if (found) begin
        state_d    = S_BUSY;
        ptr_d      = win;
        cnt_d      = '0;
        grant_d    = NUM_CH'(1) << win;
        busy_d     = 1'b1;
        mem_req_d  = 1'b1;
        mem_addr_d = ch_addr[win];
        mem_data_d = ch_wdata[win];
        mem_f3_d   = ch_f3[win];
        mem_we_d   = i_we[win];
      end
      S_BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (i_mem_ack) begin
          state_d   = S_DONE;
          ack_d     = grant_q;
          rdata_d   = mem_we_q ? '0 : i_mem_data;
          mem_req_d = 1'b0;
        end else if (TIMEOUT_CYC != 0 && cnt_q == TO_LAST_C) begin
          state_d   = S_DONE;
          ack_d     = grant_q;
          err_d     = grant_q;
          rdata_d   = '0;
          mem_req_d = 1'b0;
        end
      end
      S_DONE: begin
        // No arbitration here so the served channel has a cycle to drop its request.
        state_d = S_IDLE;
        ack_d   = '0;
        err_d   = '0;
        grant_d = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= CW'(NUM_CH - 1);
      cnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      grant_q    <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_f3_q   <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_f3_q   <= mem_f3_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign o_ack        = ack_q;
  assign o_err        = err_q;
  assign o_rdata      = rdata_q;
  assign o_grant      = grant_q;
  assign o_busy       = busy_q;
  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data   = mem_data_q;
  assign o_mem_funct3 = mem_f3_q;
  assign o_mem_we     = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (fixed priority with timeout, round-robin without timeout),
// each with a memory responder, a requester that drops on ack, and an expected-completion queue.
module tb_mem_port_arbiter;
  localparam int NC = 3;
  localparam int XL = 32;

  typedef struct {
    int ch; logic [31:0] addr, wdata, rdata; logic [2:0] f3; logic we, err;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [NC-1:0]          req[2], we[2], ack[2], err[2], grant[2];
  logic [NC-1:0][XL-1:0]  addr[2], wdata[2];
  logic [NC-1:0][2:0]     f3[2];
  logic [XL-1:0]          rdata[2], m_addr[2], m_data[2], m_rdata[2];
  logic                   busy[2], m_req[2], m_we[2];
  logic                   m_ack[2] = '{1'b0, 1'b0};
  logic [2:0]             m_f3[2];
  int                     issued[2][NC], done[2][NC], mode[2], lat[2], lat_cnt[2], rise_cyc[2];
  logic                   prev_req[2];
  exp_t                   sbq[2][$];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    for (genvar c = 0; c < NC; c++) begin : g_req
      assign req[d][c] = (issued[d][c] != done[d][c]);
    end
    mem_port_arbiter #(.NUM_CH(NC), .XLEN(XL), .ARB_MODE(d), .TIMEOUT_CYC(d == 0 ? 8 : 0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req[d]), .i_addr(addr[d]), .i_wdata(wdata[d]),
      .i_funct3(f3[d]), .i_we(we[d]), .o_ack(ack[d]), .o_err(err[d]), .o_rdata(rdata[d]),
      .o_grant(grant[d]), .o_busy(busy[d]), .o_mem_req(m_req[d]), .o_mem_addr(m_addr[d]),
      .o_mem_data(m_data[d]), .o_mem_funct3(m_f3[d]), .o_mem_we(m_we[d]),
      .i_mem_ack(m_ack[d]), .i_mem_data(m_rdata[d]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic exp_t mk(input int c, input logic [31:0] a, wd, input logic [2:0] fn,
                              input logic w, e_err);
    exp_t e;
    e.ch = c; e.addr = a; e.wdata = wd; e.f3 = fn; e.we = w; e.err = e_err;
    e.rdata = (w || e_err) ? 32'h0 : mem_model(a);
    return e;
  endfunction

  // Memory: modes 0 = ack after lat cycles, 1 = never ack, 2 = ack held high unconditionally.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (mode[d] == 2) begin
        m_ack[d] = 1'b1; m_rdata[d] = 32'h1234_5678;
      end else if (m_ack[d]) m_ack[d] = 1'b0;
      else if (m_req[d] && mode[d] == 0) begin
        if (lat_cnt[d] >= lat[d] - 1) begin
          m_ack[d] = 1'b1; m_rdata[d] = mem_model(m_addr[d]); lat_cnt[d] = 0;
        end else lat_cnt[d]++;
      end else lat_cnt[d] = 0;
    end
  end

  // Monitor: checks each new external request and each completion against the queue front.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) prev_req[d] = 1'b0;
      else begin
        if (m_req[d] && !prev_req[d]) begin
          rise_cyc[d] = cyc;
          if (sbq[d].size() == 0) chk("req_unexpected", 32'(m_req[d]), 0);
          else begin
            e = sbq[d][0];
            chk("grant", 32'(grant[d]), 1 << e.ch);
            chk("mem_addr", m_addr[d], e.addr);
            chk("mem_we", 32'(m_we[d]), 32'(e.we));
            chk("mem_f3", 32'(m_f3[d]), 32'(e.f3));
            chk("mem_data", m_data[d], e.wdata);
          end
        end
        prev_req[d] = m_req[d];
        if (ack[d] != '0) begin
          if (sbq[d].size() == 0) chk("ack_unexpected", 32'(ack[d]), 0);
          else begin
            e = sbq[d].pop_front();
            chk("ack", 32'(ack[d]), 1 << e.ch);
            chk("err", 32'(err[d]), e.err ? (1 << e.ch) : 0);
            chk("rdata", rdata[d], e.rdata);
            chk("mem_req_drop", 32'(m_req[d]), 0);
            if (e.err) chk("timeout_lat", cyc - rise_cyc[d], 8);
            done[d][e.ch]++;
          end
        end
      end
    end
  end

  task automatic issue(input int d, c, input logic [31:0] a, wd, input logic [2:0] fn,
                       input logic w, e_err);
    addr[d][c] = a; wdata[d][c] = wd; f3[d][c] = fn; we[d][c] = w;
    sbq[d].push_back(mk(c, a, wd, fn, w, e_err));
    issued[d][c]++;
  endtask

  function automatic bit pending(input int d);
    bit p = busy[d];
    for (int c = 0; c < NC; c++) if (issued[d][c] != done[d][c]) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input int d, input string tag);
    int n = 0;
    while (pending(d) && n < 300) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 300), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; f3[d] = '0; we[d] = '0; mode[d] = 0; lat[d] = 2;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(ack[d]), 0);     chk("rst_err", 32'(err[d]), 0);
      chk("rst_grant", 32'(grant[d]), 0); chk("rst_busy", 32'(busy[d]), 0);
      chk("rst_mem_req", 32'(m_req[d]), 0); chk("rst_rdata", rdata[d], 0);
      chk("rst_mem_addr", m_addr[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single lw on channel 0, memory latency 2
    issue(0, 0, 32'h100, 32'h0, 3'b010, 1'b0, 1'b0);
    wait_drain(0, "t1_drain");
    chk("t1_grant_idle", 32'(grant[0]), 0);
    chk("t1_busy_idle", 32'(busy[0]), 0);

    // Fixed priority: ch0 and ch1 together, ch0 first
    issue(0, 0, 32'h200, 32'h11, 3'b010, 1'b0, 1'b0);
    issue(0, 1, 32'h300, 32'h22, 3'b010, 1'b0, 1'b0);
    wait_drain(0, "t2_drain");

    // Store byte on ch1: rdata must stay 0 even though memory drives data
    issue(0, 1, 32'h20, 32'hAB, 3'b000, 1'b1, 1'b0);
    wait_drain(0, "t3_drain");

    // Timeout with no ack; inputs changed mid-flight must not leak through
    mode[0] = 1;
    issue(0, 0, 32'h40, 32'h0, 3'b010, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    addr[0][0] = 32'hFFF0;
    chk("hold_addr", m_addr[0], 32'h40);
    wait_drain(0, "t4_drain");
    mode[0] = 2;
    repeat (4) @(negedge clk);
    chk("late_ack_busy", 32'(busy[0]), 0);
    chk("late_ack_req", 32'(m_req[0]), 0);
    mode[0] = 0;
    repeat (2) @(negedge clk);

    // Round-robin, all three channels requesting continuously for 6 transactions
    lat[1] = 1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++)
        issue(1, c, 32'h1000 + 32'(c) * 32'h10, 32'h77 + 32'(c), 3'b010, 1'(c == 2), 1'b0);
    wait_drain(1, "rr_drain");

    // Reset during BUSY: ch2 in flight (pointer at 0), ch0 waiting
    issue(1, 0, 32'h500, 32'h0, 3'b010, 1'b0, 1'b0);
    wait_drain(1, "rst_setup_drain");
    mode[1] = 1;
    issue(1, 2, 32'h600, 32'h66, 3'b001, 1'b1, 1'b0);
    issue(1, 0, 32'h700, 32'h0, 3'b010, 1'b0, 1'b0);
    n = 0;
    while (grant[1] != 3'b100 && n < 50) begin @(negedge clk); n++; end
    chk("rst_pre_grant", 32'(grant[1]), 32'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_req", 32'(m_req[1]), 0);
    chk("rst_busy_grant", 32'(grant[1]), 0);
    chk("rst_busy_ack", 32'(ack[1]), 0);
    sbq[1].delete();
    sbq[1].push_back(mk(0, 32'h700, 32'h0, 3'b010, 1'b0, 1'b0));
    sbq[1].push_back(mk(2, 32'h600, 32'h66, 3'b001, 1'b1, 1'b0));
    mode[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(1, "rst_post_drain");

    repeat (3) @(negedge clk);
    chk("sb0_empty", 32'(sbq[0].size()), 0);
    chk("sb1_empty", 32'(sbq[1].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel memory port arbiter for the RV32I_Zicsr core.
- Merges the core's separate request/acknowledge memory ports onto one external memory port. Typical channels are instruction fetch and data memory, with CSR/debug masters added through NUM_CH.
- Provides fixed-priority or round-robin arbitration, an optional ack timeout with an error flag, and one outstanding transaction at a time.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8)
- XLEN, 32, address/data width
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
- TIMEOUT_CYC, 0, cycles to wait for i_mem_ack before forcing an error completion; 0 disables the timeout

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_CH  per-channel request, held high until that channel's o_ack
- i_addr  in  NUM_CH*XLEN  channel c address at bits [c*XLEN +: XLEN]
- i_wdata  in  NUM_CH*XLEN  channel c store data
- i_funct3  in  NUM_CH*3  channel c access size/sign (RV32I funct3)
- i_we  in  NUM_CH  1 = write, 0 = read
- o_ack  out  NUM_CH  one-cycle completion pulse to the granted channel
- o_err  out  NUM_CH  pulses together with o_ack when the transaction timed out
- o_rdata  out  XLEN  read data, valid in the o_ack cycle
- o_grant  out  NUM_CH  one-hot grant of the current owner; zero when idle
- o_busy  out  1  high in the BUSY and DONE states
- o_mem_req  out  1  external request
- o_mem_addr  out  XLEN  external address
- o_mem_data  out  XLEN  external write data
- o_mem_funct3  out  3  external access size
- o_mem_we  out  1  external read(0)/write(1)
- i_mem_ack  in  1  external completion
- i_mem_data  in  XLEN  external read data

Behaviour:
- Clock and reset: one clock (i_clk). Reset is asynchronous, active-low (i_rst_n).
- Reset values:
  - All outputs are 0; the state is IDLE; the timeout counter is 0.
  - The round-robin pointer is NUM_CH-1, so channel 0 has first priority after reset.
- All outputs are registered.

States:
- IDLE:
  - If any i_req bit is set, pick winner w:
    - ARB_MODE=0: lowest set index.
    - ARB_MODE=1: first set index searching from (ptr+1) mod NUM_CH upward with wrap.
  - On the next edge: latch w's addr/wdata/funct3/we into the o_mem_* registers, set o_mem_req=1, set o_grant=onehot(w), set ptr=w, go to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - o_mem_req and all o_mem_* outputs are held stable. The counter increments each cycle.
  - On i_mem_ack:
    - Next edge: o_ack[w]=1; o_rdata = i_mem_data for reads, 0 for writes; o_mem_req=0; go to DONE.
  - Else, if TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC-1:
    - Next edge: o_ack[w]=1, o_err[w]=1, o_rdata=0, o_mem_req=0; go to DONE.
  - i_mem_ack has priority over timeout in the same cycle.
- DONE:
  - Lasts exactly one cycle. o_ack and o_err return to 0, o_grant becomes 0, the counter clears.
  - No arbitration happens in DONE, so the just-served channel can drop i_req without being re-granted. Go to IDLE.

Latency and throughput:
- i_req rising at edge n gives o_mem_req high after edge n+1.
- i_mem_ack sampled at edge k gives o_ack high after edge k.
- Minimum period is 3 cycles plus memory latency per transaction.

Boundary rules:
- i_mem_ack seen in IDLE or DONE is ignored.
- Changes to i_req, i_addr or the other inputs of a channel during BUSY do not affect the transaction in flight. Dropping i_req does not abort it.
- Requests arriving during BUSY or DONE wait. None are lost while i_req is held.
- With ARB_MODE=1 and all channels requesting continuously, grants rotate 0,1,…,NUM_CH-1,0. No channel waits more than NUM_CH-1 transactions.
- Reset in any state:
  - Drops o_mem_req immediately and discards the in-flight transaction with no o_ack.
  - Requesters reissue after reset.
- The counter is wide enough for TIMEOUT_CYC and saturates; it does not wrap.

Test Plan:
- Single channel 0 read, addr 0x0000_0100, memory acks 2 cycles after o_mem_req with 0xDEAD_BEEF -> o_mem_addr=0x100, o_mem_we=0; o_ack[0] pulses once with o_rdata=0xDEAD_BEEF; o_grant returns to 0.
- ARB_MODE=0, ch0 and ch1 request in the same cycle, both held -> ch0 served first, then ch1 with no duplicate ch0 grant; o_ack order is 0 then 1.
- ARB_MODE=1, NUM_CH=3, all three requesting continuously (requests re-raised after ack) for 6 transactions -> grant sequence 0,1,2,0,1,2.
- Ch1 store sb, addr 0x20, wdata 0x0000_00AB, funct3=000 -> o_mem_we=1, o_mem_data=0xAB, o_mem_funct3=000; o_ack[1] with o_rdata=0.
- TIMEOUT_CYC=8, memory never acks -> o_ack[0] and o_err[0] pulse together 8 cycles after o_mem_req rose; o_mem_req drops; a late i_mem_ack is ignored.
- i_rst_n asserted while in BUSY -> o_mem_req and o_grant are 0 at once with no o_ack. After release, the held request is re-granted starting from channel 0.
